// File: rtl/seg_scan_display.sv
// Scanned 7-segment display of a one-hot DIP switch value plus a history of earlier accepted values.
// Define SEG_SCAN_DEBOUNCE_EN to debounce the synchronised switch; otherwise it is used directly.
module seg_scan_display #(
  parameter int SW_WIDTH        = 8,
  parameter int NUM_DIGITS      = 4,
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SW_WIDTH-1:0]   switch,
  output logic [NUM_DIGITS-1:0] ctrl,
  output logic [7:0]            segment,
  output logic                  accept_stb
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  // Digit codes: 1..9 are values, 0 is an empty slot, F is the invalid-input dash.
  localparam logic [3:0] CODE_EMPTY = 4'h0;
  localparam logic [3:0] CODE_DASH  = 4'hF;

  function automatic logic [7:0] glyph(input logic [3:0] code);
    case (code)
      4'd1:      glyph = 8'b0110_0000;
      4'd2:      glyph = 8'b1101_1010;
      4'd3:      glyph = 8'b1111_0010;
      4'd4:      glyph = 8'b0110_0110;
      4'd5:      glyph = 8'b1011_0110;
      4'd6:      glyph = 8'b1011_1110;
      4'd7:      glyph = 8'b1110_0000;
      4'd8:      glyph = 8'b1111_1110;
      4'd9:      glyph = 8'b1111_0110;
      CODE_DASH: glyph = 8'b0000_0010;
      default:   glyph = 8'b0000_0000;
    endcase
  endfunction

  logic [SW_WIDTH-1:0] sync1, sync2, sw_db;

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= switch;
      sync2 <= sync1;
    end
  end

`ifdef SEG_SCAN_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [DW-1:0] db_cnt;

  // db_cnt counts edges at which sync2 held a value different from sw_db;
  // sync1 != sync2 means sync2 is about to change, so the run restarts.
  always_ff @(posedge clk) begin
    if (rst) begin
      db_cnt <= '0;
      sw_db  <= '0;
    end else if (sync2 == sw_db) begin
      db_cnt <= '0;
    end else if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
      sw_db  <= sync2;
      db_cnt <= '0;
    end else if (sync1 != sync2) begin
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end
`else
  assign sw_db = sync2;
`endif

  logic [3:0] dec_val;
  logic [3:0] ones_cnt;
  logic       dec_valid;
  logic [3:0] digit0_code;

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    dec_val  = CODE_EMPTY;
    ones_cnt = '0;
    for (int k = 0; k < SW_WIDTH; k++) begin
      if (sw_db[k]) begin
        dec_val  = 4'(k + 1);
        ones_cnt = ones_cnt + 4'd1;
      end
    end
    dec_valid   = (ones_cnt == 4'd1);
    digit0_code = dec_valid ? dec_val : CODE_DASH;
  end

  logic [3:0] last;
  logic       accept;

  // sw_db only moves on a commit, so evaluating every clock is the same as evaluating on commit.
  assign accept = dec_valid && (dec_val != last);

  always_ff @(posedge clk) begin
    if (rst) begin
      last       <= CODE_EMPTY;
      accept_stb <= 1'b0;
    end else begin
      accept_stb <= accept;
      if (accept) last <= dec_val;
    end
  end

  logic [PW-1:0] pre;
  logic [IW-1:0] idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      pre <= '0;
      idx <= '0;
    end else if (pre == PW'(SCAN_DIV - 1)) begin
      pre <= '0;
      idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  logic [3:0] sel_code;

  generate
    if (NUM_DIGITS > 1) begin : g_hist
      logic [3:0] hist [1:NUM_DIGITS-1];

      // NOTE: the history array is reset explicitly because an empty slot must show blank after reset.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int j = 1; j < NUM_DIGITS; j++) hist[j] <= CODE_EMPTY;
        end else if (accept) begin
          hist[1] <= last;
          for (int j = 2; j < NUM_DIGITS; j++) hist[j] <= hist[j-1];
        end
      end

      always_comb begin
        sel_code = digit0_code;
        if (idx != '0 && int'(idx) < NUM_DIGITS) sel_code = hist[idx];
      end
    end else begin : g_single
      always_comb sel_code = digit0_code;
    end
  endgenerate

  // Output registers take the live digit content, so a shift shows up within one clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl    <= '1;
      segment <= '0;
    end else begin
      ctrl    <= ~(NUM_DIGITS'(1) << idx);
      segment <= glyph(sel_code);
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// Bench for seg_scan_display: accept pulses checked by a scoreboard, display checked by scan captures.
module tb_seg_scan_display;

  localparam int NDIG = 4;
  localparam int SDIV = 4;
  localparam int DBC  = 3;
`ifdef SEG_SCAN_DEBOUNCE_EN
  localparam int LAT = 2 + DBC;
`else
  localparam int LAT = 2;
`endif

  localparam logic [7:0] B    = 8'b0000_0000;
  localparam logic [7:0] DASH = 8'b0000_0010;
  localparam logic [7:0] G1 = 8'b0110_0000, G2 = 8'b1101_1010, G3 = 8'b1111_0010;
  localparam logic [7:0] G4 = 8'b0110_0110, G5 = 8'b1011_0110, G8 = 8'b1111_1110;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [7:0]      switch = '0;
  logic [NDIG-1:0] ctrl;
  logic [7:0]      segment;
  logic            accept_stb;

  seg_scan_display #(
    .SW_WIDTH(8), .NUM_DIGITS(NDIG), .SCAN_DIV(SDIV), .DEBOUNCE_CYCLES(DBC)
  ) dut (
    .clk(clk), .rst(rst), .switch(switch),
    .ctrl(ctrl), .segment(segment), .accept_stb(accept_stb)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  int exp_q[$];
  logic [7:0] cap [NDIG];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every accept pulse must match the oldest expected accept cycle.
  always @(negedge clk) begin
    int e;
    if (accept_stb === 1'b1) begin
      e = (exp_q.size() > 0) ? exp_q[0] : -1;
      check("accept_cycle", cyc, e);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
  end

  task automatic apply(input logic [7:0] v, input bit expect_acc);
    @(negedge clk);
    switch = v;
    if (expect_acc) exp_q.push_back(cyc + LAT + 1);
    repeat (LAT + 4) @(negedge clk);
  endtask

  task automatic scan_check(input string tag, input logic [NDIG-1:0][7:0] exp);
    logic [NDIG-1:0] m;
    for (int i = 0; i < NDIG; i++) cap[i] = 'x;
    repeat (24) begin
      @(negedge clk);
      for (int i = 0; i < NDIG; i++) begin
        m = ~(NDIG'(1) << i);
        if (ctrl === m) cap[i] = segment;
      end
    end
    for (int i = 0; i < NDIG; i++) check($sformatf("%s_digit%0d", tag, i), cap[i], exp[i]);
  endtask

  initial begin
    logic [NDIG-1:0] m;
    rst = 1'b1;
    switch = '0;
    repeat (3) @(negedge clk);
    check("rst_ctrl", ctrl, 4'hF);
    check("rst_segment", segment, B);
    check("rst_accept", accept_stb, 1'b0);

    rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      m = ~(NDIG'(1) << ((k - 1) / 4));
      check($sformatf("idle_ctrl_%0d", k), ctrl, m);
      check($sformatf("idle_seg_%0d", k), segment, (k <= 4) ? DASH : B);
    end

    apply(8'b0000_0100, 1'b1);
    scan_check("first3", {B, B, B, G3});

    apply(8'b0000_0001, 1'b1);
    apply(8'b0000_0010, 1'b1);
    apply(8'b0000_0100, 1'b1);
    apply(8'b0000_1000, 1'b1);
    scan_check("seq4", {G1, G2, G3, G4});
    apply(8'b0001_0000, 1'b1);
    scan_check("seq5", {G2, G3, G4, G5});

    apply(8'b0000_0011, 1'b0);
    scan_check("multihot", {G2, G3, G4, DASH});
    apply(8'b0001_0000, 1'b0);
    scan_check("repeat5", {G2, G3, G4, G5});

`ifdef SEG_SCAN_DEBOUNCE_EN
    for (int p = 0; p < 10; p++) begin
      @(negedge clk);
      switch = (p % 2 == 0) ? 8'b0000_0001 : 8'b0000_0000;
      @(negedge clk);
    end
    apply(8'b0000_0001, 1'b1);
    scan_check("bounce", {G3, G4, G5, G1});
    apply(8'b0000_0000, 1'b0);
    apply(8'b1000_0000, 1'b1);
    scan_check("top_bit", {G4, G5, G1, G8});
`else
    apply(8'b0000_0000, 1'b0);
    apply(8'b1000_0000, 1'b1);
    scan_check("top_bit", {G3, G4, G5, G8});
`endif

    @(negedge clk);
    switch = 8'b0000_0010;
    @(negedge clk);
    rst = 1'b1;
    switch = '0;
    repeat (3) @(negedge clk);
    check("midrst_ctrl", ctrl, 4'hF);
    check("midrst_segment", segment, B);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    scan_check("after_rst", {B, B, B, DASH});

    repeat (4) @(negedge clk);
    check("pending_accepts", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

endmodule
